// File: rtl/irq_timer_port.sv
// Bus-mapped interrupt timer: 16-bit prescaled down-counter driving irq, a
// software-triggered nmi pulse, and a wait-state FSM that paces every access.
module irq_timer_port #(
    parameter int PRESCALE    = 16,
    parameter int WAIT_STATES = 1,
    parameter int NMI_WIDTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic       write,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       ready,
    output logic       irq,
    output logic       nmi,
    output logic [1:0] fsm_state
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int NW = $clog2(NMI_WIDTH + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [NW-1:0] NMI_LOAD = NW'(NMI_WIDTH);
    localparam logic [3:0]    WS_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } ws_state_t;

    ws_state_t     state, state_nxt;
    logic [3:0]    ws_cnt, ws_cnt_nxt;

    logic          tmr_en, irq_en, oneshot, pending;
    logic [15:0]   reload, counter;
    logic [PW-1:0] prescaler;
    logic [7:0]    cnt_hi_snap;
    logic [NW-1:0] nmi_cnt;

    logic commit, wr, wr_ctrl, wr_status, wr_rld_lo, wr_rld_hi;
    logic snap, tick, underflow, clr_pending;

    // Handshake: an access completes in any cycle where cs & ready; ready is
    // held high whenever cs is low or the block is in reset (reset is active-low).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ws_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            ws_cnt <= ws_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ws_cnt_nxt = ws_cnt;
        ready      = 1'b1;
        case (state)
            S_IDLE: begin
                if (cs && (WAIT_STATES > 0)) begin
                    ready      = 1'b0;
                    ws_cnt_nxt = WS_LOAD;
                    state_nxt  = (WS_LOAD == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cs) begin
                    state_nxt = S_IDLE;
                end else begin
                    ready      = 1'b0;
                    ws_cnt_nxt = ws_cnt - 4'd1;
                    if (ws_cnt == 4'd1) state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (!reset) ready = 1'b1;
    end

    assign fsm_state   = state;

    assign commit      = cs & ready;
    assign wr          = commit & write;
    assign wr_ctrl     = wr & (addr == 3'd0);
    assign wr_status   = wr & (addr == 3'd1);
    assign wr_rld_lo   = wr & (addr == 3'd2);
    assign wr_rld_hi   = wr & (addr == 3'd3);
    assign snap        = commit & ~write & (addr == 3'd4);
    assign tick        = tmr_en & (prescaler == PRE_LAST);
    assign clr_pending = wr_status & data_i[0];
    // A RELOAD_HI write on the tick edge replaces the underflow entirely.
    assign underflow   = tick & (counter == 16'd0) & ~wr_rld_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_en      <= 1'b0;
            irq_en      <= 1'b0;
            oneshot     <= 1'b0;
            pending     <= 1'b0;
            reload      <= 16'hFFFF;
            counter     <= 16'hFFFF;
            prescaler   <= '0;
            cnt_hi_snap <= 8'h00;
            nmi_cnt     <= '0;
        end else begin
            if (wr_ctrl) begin
                tmr_en  <= data_i[0];
                irq_en  <= data_i[1];
                oneshot <= data_i[2];
            end else if (underflow && oneshot) begin
                tmr_en  <= 1'b0;
            end

            pending <= underflow | (pending & ~clr_pending);

            if (wr_rld_lo) reload[7:0]  <= data_i;
            if (wr_rld_hi) reload[15:8] <= data_i;

            if (wr_rld_hi)
                counter <= {data_i, reload[7:0]};
            else if (tick)
                counter <= (counter == 16'd0) ? reload : counter - 16'd1;

            if (wr_rld_hi || !tmr_en || tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);

            if (snap) cnt_hi_snap <= counter[15:8];

            if (wr_ctrl && data_i[7])
                nmi_cnt <= NMI_LOAD;
            else if (nmi_cnt != '0)
                nmi_cnt <= nmi_cnt - NW'(1);
        end
    end

    assign irq = pending & irq_en;
    assign nmi = (nmi_cnt != '0);

    always_comb begin
        data_o = 8'h00;
        if (cs) begin
            case (addr)
                3'd0:    data_o = {5'b0, oneshot, irq_en, tmr_en};
                3'd1:    data_o = {6'b0, nmi, pending};
                3'd2:    data_o = reload[7:0];
                3'd3:    data_o = reload[15:8];
                3'd4:    data_o = counter[7:0];
                3'd5:    data_o = cnt_hi_snap;
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/irq_timer_port.md
# irq_timer_port

Memory-mapped bus responder that drives the CPU `irq` and `nmi` inputs from a programmable 16-bit down-counter and a software NMI trigger. It answers CPU reads and writes on the same bus the 4510 core uses: registered address, `data_i`/`data_o`, `write`, and a `ready` wait-state output. The system decoder supplies `cs`. Software programs it, acknowledges interrupts, and reads the live count atomically.

## Interface
- `PRESCALE`, 16: clocks per counter decrement, minimum 1.
- `WAIT_STATES`, 1: `ready`-low cycles inserted per access, 0–15.
- `NMI_WIDTH`, 4: `nmi` pulse length in clocks, minimum 1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select, decoded from the registered CPU address.
- `addr`  in  3  register index, from CPU address [2:0].
- `write`  in  1  registered CPU write strobe.
- `data_i`  in  8  CPU write data.
- `data_o`  out  8  read data; combinational; 0 when `cs`=0.
- `ready`  out  1  access completes in a cycle where `cs`&`ready`.
- `irq`  out  1  level interrupt, `pending & irq_en`.
- `nmi`  out  1  registered NMI pulse.

## Operation
Register map:
- 0 CTRL, R/W.
  - bit0 `tmr_en`.
  - bit1 `irq_en`.
  - bit2 `oneshot`.
  - bit7 NMI trigger: write-only, reads 0.
- 1 STATUS.
  - bit0 `pending`: write 1 to clear.
  - bit1 `nmi_active`: read-only.
- 2 RELOAD_LO, R/W.
- 3 RELOAD_HI, R/W. Writing it also copies the full reload value into the counter and clears the prescaler.
- 4 CNT_LO, RO. Reading it captures counter[15:8] into `cnt_hi_snap`.
- 5 CNT_HI, RO. Returns `cnt_hi_snap`.
- 6, 7: read 0, writes ignored.

Counter:
- While `tmr_en`=1, a prescaler counts 0..PRESCALE-1. The tick is the cycle where the prescaler equals PRESCALE-1.
- On a tick:
  - If counter≠0, the counter decrements.
  - If counter=0, the counter reloads, `pending` sets, and `tmr_en` clears if `oneshot`=1.
- While `tmr_en`=0, the prescaler holds at 0 and the counter holds.
- Set and clear of `pending` in the same cycle: set wins.
- RELOAD_HI write coinciding with a tick: the write wins and no `pending` is set.

NMI:
- Writing CTRL with bit7=1 loads the nmi counter with NMI_WIDTH.
- `nmi` is high while that counter is nonzero. Retriggering restarts the width.

Wait-state FSM (IDLE, WAIT, DONE):
- IDLE, `cs`=1, WAIT_STATES>0: `ready`=0. Load `ws_cnt`=WAIT_STATES-1. Go to DONE if `ws_cnt` loads 0, else WAIT.
- WAIT: `ready`=0. Decrement `ws_cnt`. Go to DONE when it reaches 0.
- DONE: `ready`=1; the access completes. Next state IDLE.
- `cs` dropping in WAIT: go to IDLE.
- WAIT_STATES=0: FSM stays IDLE and `ready`=1 always.
- `ready`=1 whenever `cs`=0.

Commit rules:
- Register writes and the CNT_LO snapshot take effect at the rising edge ending a cycle with `cs`&`ready`.
- Writes use `write`=1; the snapshot requires `write`=0 and `addr`=4.
- Back-to-back accesses (`cs` held high) each pay WAIT_STATES cycles.

## Timing
Reset values:
- CTRL=0, `pending`=0.
- RELOAD=0xFFFF, counter=0xFFFF, prescaler=0, `cnt_hi_snap`=0.
- nmi counter=0, FSM=IDLE.

Outputs while `reset`=0:
- `irq`=0, `nmi`=0, `ready`=1.
- `data_o`=0 when `cs`=0.

Reset mid-access or mid-NMI pulse aborts immediately.

Latencies:
- `irq`: high in the cycle after the edge that sets `pending`. Low in the cycle after the W1C edge or after an `irq_en`=0 write.
- `nmi`: rises the cycle after the CTRL write edge and stays high exactly NMI_WIDTH cycles.
- Counter period: (reload+1)·PRESCALE clocks between `pending` sets.

## Test plan
- Reset released, idle → `irq`=0, `nmi`=0, `ready`=1; reads return RELOAD_LO=0xFF, CNT_LO=0xFF.
- PRESCALE=1, WAIT_STATES=0. Write RELOAD_LO=0x03, RELOAD_HI=0x00, CTRL=0x03 → first `pending` after 4 clocks, `irq` the next cycle, then every 4 clocks. W1C STATUS=0x01 → `irq` low next cycle.
- Same setup with CTRL=0x07 → a single `pending`; CTRL reads back 0x06 and the counter holds 0x0003.
- WAIT_STATES=2, read of addr 1 → `ready` low 2 cycles then high 1 cycle. Two back-to-back reads take 6 cycles. Dropping `cs` mid-WAIT → IDLE, no commit.
- Write CTRL=0x80 with NMI_WIDTH=4 → `nmi` high exactly 4 cycles. Retrigger at cycle 2 → high 6 cycles total. CTRL reads 0x00.
- Counter at 0x0100 with decrement pending. Read CNT_LO=0x00, let the counter decrement to 0x00FF, then read CNT_HI → 0x01 (snapshot). W1C coinciding with underflow → `pending` stays 1.
